// File: rtl/pbkdf2_sha512_ctrl_pkg.sv
// Shared types and widths for the PBKDF2-HMAC-SHA512 block controller.
package pbkdf2_sha512_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        ACC    = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam int SALT_W = 256;
    localparam int BLK_W  = 32;
    localparam int DK_W   = 512;
    localparam int KEY_W  = 1024;
    localparam int MSG_W  = 512;

    localparam logic MODE_36B = 1'b0;
    localparam logic MODE_64B = 1'b1;

    // First-call message: salt, big-endian block index, zero tail.
    function automatic logic [MSG_W-1:0] first_msg(input logic [SALT_W-1:0] salt,
                                                   input logic [BLK_W-1:0]  blk);
        return {salt, blk, {(MSG_W-SALT_W-BLK_W){1'b0}}};
    endfunction

endpackage

// File: rtl/pbkdf2_sha512_ctrl_if.sv
// Request/response channels between the key-search front end and the PBKDF2 block controller.
interface pbkdf2_sha512_ctrl_if
    import pbkdf2_sha512_ctrl_pkg::*;
#(
    parameter int ITER_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [KEY_W-1:0]  req_key;
    logic [SALT_W-1:0] req_salt;
    logic [BLK_W-1:0]  req_blk;
    logic [ITER_W-1:0] req_iter;
    logic              resp_valid;
    logic              resp_ready;
    logic [DK_W-1:0]   resp_dk;

    modport master (
        output req_valid, req_key, req_salt, req_blk, req_iter, resp_ready,
        input  req_ready, resp_valid, resp_dk
    );

    modport slave (
        input  req_valid, req_key, req_salt, req_blk, req_iter, resp_ready,
        output req_ready, resp_valid, resp_dk
    );
endinterface

// File: rtl/pbkdf2_sha512_ctrl.sv
// Sequences one hmac engine through c calls and XOR-accumulates U1..Uc into T_i.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for a request
// LAUNCH | hmac held in reset one cycle, mode/msg stable
// RUN    | hmac running, waiting for done
// ACC    | fold oH into T, chain oH as next message
// RESP   | resp_valid=1 with T until resp_ready
module pbkdf2_sha512_ctrl
    import pbkdf2_sha512_ctrl_pkg::*;
#(
    parameter int ITER_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    pbkdf2_sha512_ctrl_if.slave  req_if,
    output logic                 hmac_run,
    input  logic                 hmac_done,
    output logic                 hmac_mode,
    output logic [KEY_W-1:0]     hmac_key,
    output logic [MSG_W-1:0]     hmac_msg,
    input  logic [DK_W-1:0]      hmac_oH
);

    state_t            state;
    logic [ITER_W-1:0] remaining;
    logic [DK_W-1:0]   t_acc;
    logic              first;

    assign req_if.resp_dk = t_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            req_if.req_ready  <= 1'b1;
            req_if.resp_valid <= 1'b0;
            hmac_run          <= 1'b0;
            hmac_mode         <= MODE_36B;
            hmac_key          <= '0;
            hmac_msg          <= '0;
            remaining         <= '0;
            t_acc             <= '0;
            first             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_if.req_valid) begin
                        hmac_key         <= req_if.req_key;
                        hmac_msg         <= first_msg(req_if.req_salt, req_if.req_blk);
                        hmac_mode        <= MODE_36B;
                        // A zero iteration count behaves as a single iteration.
                        remaining        <= (req_if.req_iter == '0) ? ITER_W'(1) : req_if.req_iter;
                        first            <= 1'b1;
                        req_if.req_ready <= 1'b0;
                        hmac_run         <= 1'b0;
                        state            <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    hmac_run <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    if (hmac_done) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    t_acc     <= first ? hmac_oH : (t_acc ^ hmac_oH);
                    first     <= 1'b0;
                    remaining <= remaining - ITER_W'(1);
                    hmac_run  <= 1'b0;
                    if (remaining == ITER_W'(1)) begin
                        req_if.resp_valid <= 1'b1;
                        state             <= RESP;
                    end else begin
                        hmac_mode <= MODE_64B;
                        hmac_msg  <= hmac_oH;
                        state     <= LAUNCH;
                    end
                end
                RESP: begin
                    if (req_if.resp_ready) begin
                        req_if.resp_valid <= 1'b0;
                        req_if.req_ready  <= 1'b1;
                        state             <= IDLE;
                    end
                end
                default: begin
                    req_if.resp_valid <= 1'b0;
                    req_if.req_ready  <= 1'b1;
                    hmac_run          <= 1'b0;
                    state             <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pbkdf2_sha512_ctrl.sv
// Directed/random bench for pbkdf2_sha512_ctrl against a mock hmac and an XOR-chain reference.
module tb_pbkdf2_sha512_ctrl;

    localparam int DLY = 9;            // mock raises done so RUN lasts DLY+1 cycles
    localparam int EDGES_PER_CALL = DLY + 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          hmac_run;
    logic          hmac_done;
    logic          hmac_mode;
    logic [1023:0] hmac_key;
    logic [511:0]  hmac_msg;
    logic [511:0]  hmac_oH;

    pbkdf2_sha512_ctrl_if #(.ITER_W(32)) rif ();

    pbkdf2_sha512_ctrl #(.ITER_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_if    (rif.slave),
        .hmac_run  (hmac_run),
        .hmac_done (hmac_done),
        .hmac_mode (hmac_mode),
        .hmac_key  (hmac_key),
        .hmac_msg  (hmac_msg),
        .hmac_oH   (hmac_oH)
    );

    // Mock hmac: logs inputs at start, returns preloaded or random oH after DLY run cycles.
    logic [3:0]    mcnt;
    logic [511:0]  preload_q[$];
    logic [511:0]  oh_log[$];
    logic          mode_log[$];
    logic [511:0]  msg_log[$];
    logic [1023:0] key_log[$];

    always @(posedge clk) begin
        logic [511:0] v;
        if (!hmac_run) begin
            mcnt      <= '0;
            hmac_done <= 1'b0;
        end else if (!hmac_done) begin
            if (mcnt == 0) begin
                mode_log.push_back(hmac_mode);
                msg_log.push_back(hmac_msg);
                key_log.push_back(hmac_key);
            end
            mcnt <= mcnt + 4'd1;
            if (mcnt == 4'(DLY - 1)) begin
                if (preload_q.size() > 0) v = preload_q.pop_front();
                else for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
                oh_log.push_back(v);
                hmac_oH   <= v;
                hmac_done <= 1'b1;
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    logic [1023:0] cur_key;
    logic [511:0]  cur_msg0;
    int            cur_calls;
    int            edges;

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1023:0] rnd_key();
        logic [1023:0] k;
        for (int i = 0; i < 32; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    function automatic logic [255:0] rnd_salt();
        logic [255:0] s;
        for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom;
        return s;
    endfunction

    task automatic send_req(input logic [1023:0] k, input logic [255:0] s,
                            input logic [31:0] b, input logic [31:0] it);
        oh_log.delete(); mode_log.delete(); msg_log.delete(); key_log.delete();
        cur_key   = k;
        cur_msg0  = {s, b, 224'h0};
        cur_calls = (it == 0) ? 1 : int'(it);
        @(negedge clk);
        chk("req_ready_idle", 1024'(rif.req_ready), 1024'(1));
        rif.req_key   = k;
        rif.req_salt  = s;
        rif.req_blk   = b;
        rif.req_iter  = it;
        rif.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rif.req_valid = 1'b0;
        rif.req_key   = '0;
        rif.req_salt  = '0;
    endtask

    task automatic wait_resp();
        edges = 0;
        while (!rif.resp_valid && edges < 2000) begin
            @(negedge clk);
            edges++;
        end
        chk("resp_timeout", 1024'(rif.resp_valid), 1024'(1));
    endtask

    task automatic check_resp();
        logic [511:0] t;
        t = '0;
        foreach (oh_log[i]) t ^= oh_log[i];
        chk("latency", 1024'(edges), 1024'(cur_calls * EDGES_PER_CALL));
        chk("call_count", 1024'(mode_log.size()), 1024'(cur_calls));
        chk("dk", 1024'(rif.resp_dk), 1024'(t));
        for (int j = 0; j < mode_log.size() && j < cur_calls; j++) begin
            chk("mode", 1024'(mode_log[j]), 1024'(j == 0 ? 0 : 1));
            chk("msg", 1024'(msg_log[j]), 1024'(j == 0 ? cur_msg0 : oh_log[j-1]));
            chk("key", key_log[j], cur_key);
        end
    endtask

    task automatic release_resp();
        rif.resp_ready = 1'b1;
        @(negedge clk);
        rif.resp_ready = 1'b0;
        chk("resp_valid_drop", 1024'(rif.resp_valid), 1024'(0));
        chk("req_ready_back", 1024'(rif.req_ready), 1024'(1));
    endtask

    initial begin
        logic [511:0] pat;
        logic [511:0] held_dk;
        int           n0;

        rif.req_valid  = 1'b0;
        rif.req_key    = '0;
        rif.req_salt   = '0;
        rif.req_blk    = '0;
        rif.req_iter   = '0;
        rif.resp_ready = 1'b0;
        hmac_oH        = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("rst_req_ready", 1024'(rif.req_ready), 1024'(1));
        chk("rst_resp_valid", 1024'(rif.resp_valid), 1024'(0));
        chk("rst_hmac_run", 1024'(hmac_run), 1024'(0));
        chk("rst_hmac_mode", 1024'(hmac_mode), 1024'(0));
        chk("rst_resp_dk", 1024'(rif.resp_dk), 1024'(0));

        // iter=1 with a byte-counter pattern: one call, resp_valid in cycle accept+13
        for (int i = 0; i < 64; i++) pat[i*8 +: 8] = 8'(i);
        preload_q.push_back(pat);
        send_req(rnd_key(), rnd_salt(), 32'd1, 32'd1);
        wait_resp();
        check_resp();
        chk("dk_pattern", 1024'(rif.resp_dk), 1024'(pat));
        chk("latency_13", 1024'(edges + 1), 1024'(13));
        release_resp();

        // iter=3 with oH 1,2,4
        preload_q.push_back(512'h1);
        preload_q.push_back(512'h2);
        preload_q.push_back(512'h4);
        send_req(rnd_key(), rnd_salt(), 32'd2, 32'd3);
        wait_resp();
        check_resp();
        chk("dk_7", 1024'(rif.resp_dk), 1024'(7));
        release_resp();

        // iter=0 behaves as iter=1
        send_req(rnd_key(), rnd_salt(), $urandom, 32'd0);
        wait_resp();
        check_resp();
        release_resp();

        // random requests
        for (int r = 0; r < 6; r++) begin
            send_req(rnd_key(), rnd_salt(), $urandom, 32'($urandom_range(0, 5)));
            wait_resp();
            check_resp();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_resp();
        end

        // back-pressure: hold resp_ready low, pulse a competing request
        send_req(rnd_key(), rnd_salt(), 32'd7, 32'd2);
        wait_resp();
        check_resp();
        held_dk = rif.resp_dk;
        n0 = mode_log.size();
        for (int c = 0; c < 20; c++) begin
            rif.req_valid = (c == 5);
            rif.req_iter  = 32'd1;
            rif.req_key   = rnd_key();
            @(negedge clk);
            chk("hold_valid", 1024'(rif.resp_valid), 1024'(1));
            chk("hold_dk", 1024'(rif.resp_dk), 1024'(held_dk));
            chk("hold_req_ready", 1024'(rif.req_ready), 1024'(0));
        end
        rif.req_valid = 1'b0;
        release_resp();
        repeat (4) begin
            @(negedge clk);
            chk("no_stray_run", 1024'(hmac_run), 1024'(0));
        end
        chk("no_stray_call", 1024'(mode_log.size()), 1024'(n0));

        // reset during the second RUN, then a clean request
        send_req(rnd_key(), rnd_salt(), 32'd3, 32'd3);
        edges = 0;
        while (mode_log.size() < 2 && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        chk("reach_run2", 1024'(mode_log.size()), 1024'(2));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_req_ready", 1024'(rif.req_ready), 1024'(1));
        chk("mid_rst_hmac_run", 1024'(hmac_run), 1024'(0));
        chk("mid_rst_resp_valid", 1024'(rif.resp_valid), 1024'(0));
        chk("mid_rst_resp_dk", 1024'(rif.resp_dk), 1024'(0));
        repeat (2) @(negedge clk);
        send_req(rnd_key(), rnd_salt(), 32'd4, 32'd4);
        wait_resp();
        check_resp();
        release_resp();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
